axi_top: RTL and testbench

- Loopback bridge for evaluating an AXI path. Upstream memory-style requests are converted into internal AXI4-Lite AW/W/AR transactions.
- An internal AXI subordinate turns those transactions back into a downstream memory-style request port.
- Downstream memory responses return as AXI R/B beats, which are delivered upstream as memory responses.
- Single clock domain. Sits between a memory-protocol master and a simple SRAM-like memory.

---
 rtl/axi_top.sv | 164 ++++++++++++++++
 tb/tb_axi_top.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_top.sv
// rtl/axi_top.sv - memory-request to AXI4-Lite loopback bridge with in-order response tracking
module axi_top #(
  parameter int MemAddrWidth = 32,
  parameter int AxiAddrWidth = 32,
  parameter int DataWidth    = 32,
  parameter int MaxRequests  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_req_i,
  input  logic [MemAddrWidth-1:0] mem_addr_i,
  input  logic                    mem_we_i,
  input  logic [DataWidth-1:0]    mem_wdata_i,
  input  logic [DataWidth/8-1:0]  mem_be_i,
  output logic                    mem_rsp_valid_o,
  output logic [DataWidth-1:0]    mem_rsp_rdata_o,
  output logic                    mem_rsp_error_o,
  output logic                    mem_req_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic                    mem_we_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [DataWidth/8-1:0]  mem_strb_o,
  input  logic                    mem_rvalid_i,
  input  logic [DataWidth-1:0]    mem_rdata_i,
  input  logic                    mem_err_i
);
  localparam int StrbWidth = DataWidth / 8;
  localparam int PtrWidth  = $clog2(MaxRequests);
  localparam int CntWidth  = PtrWidth + 1;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // In-order type FIFO: one bit per outstanding request, 1 = write
  logic [MaxRequests-1:0] type_q;
  logic [PtrWidth-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]    count_q, count_d, count_after_pop;
  logic                   accept, pop, popped_we;

  always_comb begin
    pop             = mem_rvalid_i && (count_q != '0);
    count_after_pop = count_q - CntWidth'(pop);
    accept          = mem_req_i && (count_after_pop != CntWidth'(MaxRequests));
    count_d         = count_after_pop + CntWidth'(accept);
    popped_we       = type_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      type_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        type_q[wr_ptr_q] <= mem_we_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Manager side: registered AW/W/AR channels, all readies tied high
  logic                    aw_valid_q, w_valid_q, ar_valid_q;
  logic [AxiAddrWidth-1:0] aw_addr_q, ar_addr_q;
  logic [DataWidth-1:0]    w_data_q;
  logic [StrbWidth-1:0]    w_strb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      aw_valid_q <= accept && mem_we_i;
      w_valid_q  <= accept && mem_we_i;
      ar_valid_q <= accept && !mem_we_i;
      if (accept && mem_we_i) begin
        aw_addr_q <= AxiAddrWidth'(mem_addr_i);
        w_data_q  <= mem_wdata_i;
        w_strb_q  <= mem_be_i;
      end
      if (accept && !mem_we_i) ar_addr_q <= AxiAddrWidth'(mem_addr_i);
    end
  end

  // Subordinate side: AXI transaction back to a downstream memory request
  logic                    mem_req_q, mem_we_q;
  logic [MemAddrWidth-1:0] mem_addr_q;
  logic [DataWidth-1:0]    mem_wdata_q;
  logic [StrbWidth-1:0]    mem_strb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
    end else begin
      mem_req_q <= (aw_valid_q && w_valid_q) || ar_valid_q;
      if (aw_valid_q && w_valid_q) begin
        mem_addr_q  <= aw_addr_q[MemAddrWidth-1:0];
        mem_we_q    <= 1'b1;
        mem_wdata_q <= w_data_q;
        mem_strb_q  <= w_strb_q;
      end else if (ar_valid_q) begin
        mem_addr_q  <= ar_addr_q[MemAddrWidth-1:0];
        mem_we_q    <= 1'b0;
        mem_wdata_q <= '0;
        mem_strb_q  <= '0;
      end
    end
  end

  // Response path: R or B beat chosen by the popped request type
  logic                 r_valid_q, b_valid_q;
  logic [1:0]           r_resp_q, b_resp_q;
  logic [DataWidth-1:0] r_data_q;
  logic                 rsp_valid_q, rsp_error_q;
  logic [DataWidth-1:0] rsp_rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      r_resp_q    <= RespOkay;
      b_resp_q    <= RespOkay;
      r_data_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      r_valid_q <= pop && !popped_we;
      b_valid_q <= pop && popped_we;
      if (pop && !popped_we) begin
        r_resp_q <= mem_err_i ? RespSlverr : RespOkay;
        r_data_q <= mem_rdata_i;
      end
      if (pop && popped_we) b_resp_q <= mem_err_i ? RespSlverr : RespOkay;
      rsp_valid_q <= r_valid_q || b_valid_q;
      if (r_valid_q) begin
        rsp_rdata_q <= r_data_q;
        rsp_error_q <= (r_resp_q == RespSlverr);
      end else if (b_valid_q) begin
        rsp_rdata_q <= '0;
        rsp_error_q <= (b_resp_q == RespSlverr);
      end
    end
  end

  assign mem_req_o       = mem_req_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_we_o        = mem_we_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_strb_o      = mem_strb_q;
  assign mem_rsp_valid_o = rsp_valid_q;
  assign mem_rsp_rdata_o = rsp_rdata_q;
  assign mem_rsp_error_o = rsp_error_q;
endmodule

// File: tb/tb_axi_top.sv
// tb/tb_axi_top.sv - directed self-checking bench for axi_top
module tb_axi_top;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mem_req_i;
  logic [31:0] mem_addr_i;
  logic        mem_we_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_be_i;
  logic        mem_rsp_valid_o;
  logic [31:0] mem_rsp_rdata_o;
  logic        mem_rsp_error_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_strb_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  int checks = 0;
  int failures = 0;

  axi_top dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i),
    .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i),
    .mem_rsp_valid_o(mem_rsp_valid_o), .mem_rsp_rdata_o(mem_rsp_rdata_o),
    .mem_rsp_error_o(mem_rsp_error_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    mem_req_i = 1'b0; mem_addr_i = '0; mem_we_i = 1'b0; mem_wdata_i = '0; mem_be_i = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, mem_req_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_we"}, mem_we_o, 0);
    check({tag, "_wdata"}, mem_wdata_o, 0);
    check({tag, "_strb"}, mem_strb_o, 0);
    check({tag, "_rsp_valid"}, mem_rsp_valid_o, 0);
    check({tag, "_rsp_rdata"}, mem_rsp_rdata_o, 0);
    check({tag, "_rsp_err"}, mem_rsp_error_o, 0);
  endtask

  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd; mem_be_i = be;
    tick();
    mem_req_i = 1'b0;
  endtask

  task automatic send_rsp(input logic [31:0] rd, input logic err);
    mem_rvalid_i = 1'b1; mem_rdata_i = rd; mem_err_i = err;
    tick();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_ni = 1'b1;
    repeat (2) tick();
    check_all_zero("post_reset");

    // single write
    send_req(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
    check("wr_lat1", mem_req_o, 0);
    tick();
    check("wr_req", mem_req_o, 1);
    check("wr_we", mem_we_o, 1);
    check("wr_addr", mem_addr_o, 32'h04);
    check("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
    check("wr_strb", mem_strb_o, 4'hF);
    tick();
    check("wr_req_pulse", mem_req_o, 0);
    send_rsp(32'h0000AAAA, 1'b0);
    check("wr_rsp_lat1", mem_rsp_valid_o, 0);
    tick();
    check("wr_rsp_valid", mem_rsp_valid_o, 1);
    check("wr_rsp_rdata", mem_rsp_rdata_o, 0);
    check("wr_rsp_err", mem_rsp_error_o, 0);
    tick();
    check("wr_rsp_pulse", mem_rsp_valid_o, 0);

    // single read with error
    send_req(1'b0, 32'h08, 32'h11111111, 4'hF);
    tick();
    check("rd_req", mem_req_o, 1);
    check("rd_we", mem_we_o, 0);
    check("rd_addr", mem_addr_o, 32'h08);
    check("rd_wdata", mem_wdata_o, 0);
    check("rd_strb", mem_strb_o, 0);
    tick();
    send_rsp(32'h12345678, 1'b1);
    tick();
    check("rd_rsp_valid", mem_rsp_valid_o, 1);
    check("rd_rsp_rdata", mem_rsp_rdata_o, 32'h12345678);
    check("rd_rsp_err", mem_rsp_error_o, 1);
    tick();

    // eight back-to-back writes, rvalid held high
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
    for (int cyc = 0; cyc < 12; cyc++) begin
      mem_req_i = (cyc < 8); mem_we_i = 1'b1; mem_be_i = 4'h3;
      mem_addr_i = 32'(4 * cyc); mem_wdata_i = 32'h100 + 32'(cyc);
      tick();
      check("b2b_req", mem_req_o, (cyc >= 1 && cyc <= 8));
      if (cyc >= 1 && cyc <= 8) begin
        check("b2b_addr", mem_addr_o, 32'(4 * (cyc - 1)));
        check("b2b_wdata", mem_wdata_o, 32'h100 + 32'(cyc - 1));
      end
      check("b2b_rsp", mem_rsp_valid_o, (cyc >= 2 && cyc <= 9));
      if (cyc >= 2 && cyc <= 9) check("b2b_rsp_rdata", mem_rsp_rdata_o, 0);
    end
    idle_inputs();
    tick();

    // overflow: 9 requests without responses, alternating write/read
    for (int cyc = 0; cyc < 11; cyc++) begin
      mem_req_i = (cyc < 9); mem_we_i = (cyc % 2 == 0); mem_be_i = 4'hF;
      mem_addr_i = 32'h100 + 32'(4 * cyc); mem_wdata_i = 32'h200 + 32'(cyc);
      tick();
      check("ovf_req", mem_req_o, (cyc >= 1 && cyc <= 8));
      if (cyc >= 1 && cyc <= 8) begin
        check("ovf_addr", mem_addr_o, 32'h100 + 32'(4 * (cyc - 1)));
        check("ovf_we", mem_we_o, ((cyc - 1) % 2 == 0));
      end
      check("ovf_no_rsp", mem_rsp_valid_o, 0);
    end
    mem_req_i = 1'b0;
    // nine response pulses: eight real, the ninth finds the FIFO empty
    for (int cyc = 0; cyc < 12; cyc++) begin
      mem_rvalid_i = (cyc < 9); mem_rdata_i = 32'hA0 + 32'(cyc); mem_err_i = (cyc == 3);
      tick();
      check("ovf_rsp", mem_rsp_valid_o, (cyc >= 1 && cyc <= 8));
      if (cyc >= 1 && cyc <= 8) begin
        check("ovf_rsp_rdata", mem_rsp_rdata_o, ((cyc - 1) % 2 == 1) ? 32'hA0 + 32'(cyc - 1) : 32'h0);
        check("ovf_rsp_err", mem_rsp_error_o, (cyc - 1 == 3));
      end
    end
    idle_inputs();
    tick();

    // spurious pulse then a mixed write/read pair
    send_rsp(32'h0BAD0BAD, 1'b1);
    tick();
    check("spur_none1", mem_rsp_valid_o, 0);
    tick();
    check("spur_none2", mem_rsp_valid_o, 0);
    send_req(1'b1, 32'h20, 32'h0000BEEF, 4'h1);
    send_req(1'b0, 32'h24, 32'h0, 4'h0);
    check("mix_wr_req", mem_req_o, 1);
    check("mix_wr_strb", mem_strb_o, 4'h1);
    tick();
    check("mix_rd_req", mem_req_o, 1);
    check("mix_rd_addr", mem_addr_o, 32'h24);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    tick();
    mem_rdata_i = 32'hCAFE;
    tick();
    mem_rvalid_i = 1'b0;
    check("mix_wr_rsp", mem_rsp_valid_o, 1);
    check("mix_wr_rdata", mem_rsp_rdata_o, 0);
    tick();
    check("mix_rd_rsp", mem_rsp_valid_o, 1);
    check("mix_rd_rdata", mem_rsp_rdata_o, 32'hCAFE);
    tick();
    check("mix_done", mem_rsp_valid_o, 0);

    // reset mid-flight loses everything in the pipeline
    send_req(1'b1, 32'h40, 32'h77, 4'hF);
    send_req(1'b0, 32'h44, 32'h0, 4'h0);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("midrst");
    tick();
    rst_ni = 1'b1;
    tick();
    send_rsp(32'h99, 1'b0);
    tick();
    check("midrst_no_req", mem_req_o, 0);
    check("midrst_no_rsp", mem_rsp_valid_o, 0);
    tick();
    check("midrst_no_rsp2", mem_rsp_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
